// File: rtl/mdc_coin_acceptor.sv
// Coin front-end: synchronises and debounces the slot sensor, classifies coins by pulse length.
// Optional MDC_COIN_COUNT_EN builds saturating audit counters for accepted coins.
module mdc_coin_acceptor #(
   parameter int unsigned DB_CYC  = 4,
   parameter int unsigned CNT_W   = 8,
   parameter int unsigned T5_MIN  = 10,
   parameter int unsigned T5_MAX  = 20,
   parameter int unsigned T10_MIN = 30,
   parameter int unsigned T10_MAX = 50
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       coin_in,
   input  logic       ack,
   output logic       hm,
   output logic       tm,
   output logic       rej,
   output logic       jam,
   output logic [7:0] coin_cnt5,
   output logic [7:0] coin_cnt10
);

   localparam int unsigned DB_W = $clog2(DB_CYC + 1);
   localparam logic [CNT_W-1:0] LEN_MAX = '1;

   typedef enum logic [1:0] {IDLE, MEASURE, CLASSIFY, JAM} state_t;

   state_t           state, state_n;
   logic [1:0]       sync;
   logic             coin_db;
   logic [DB_W-1:0]  db_cnt;
   logic [CNT_W-1:0] len, len_n;
   logic             hm_n, tm_n, rej_n, jam_n;
   logic             is5, is10, valid;

   // Input path: 2-flop synchroniser feeding a stable-count debouncer
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync    <= '0;
         coin_db <= 1'b0;
         db_cnt  <= '0;
      end else begin
         sync <= {sync[0], coin_in};
         if (sync[1] != coin_db) begin
            if (db_cnt == DB_W'(DB_CYC - 1)) begin
               coin_db <= sync[1];
               db_cnt  <= '0;
            end else begin
               db_cnt <= db_cnt + DB_W'(1);
            end
         end else begin
            db_cnt <= '0;
         end
      end
   end

   assign is5   = (len >= CNT_W'(T5_MIN))  && (len <= CNT_W'(T5_MAX));
   assign is10  = (len >= CNT_W'(T10_MIN)) && (len <= CNT_W'(T10_MAX));
   assign valid = is5 | is10;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         len   <= '0;
         hm    <= 1'b0;
         tm    <= 1'b0;
         rej   <= 1'b0;
         jam   <= 1'b0;
      end else begin
         state <= state_n;
         len   <= len_n;
         hm    <= hm_n;
         tm    <= tm_n;
         rej   <= rej_n;
         jam   <= jam_n;
      end
   end

   // Next state, length measurement and the single-slot pending coin
   always_comb begin
      state_n = state;
      len_n   = len;
      hm_n    = hm;
      tm_n    = tm;
      rej_n   = 1'b0;
      if (hm && ack) hm_n = 1'b0;
      case (state)
         IDLE: begin
            if (coin_db) begin
               len_n   = CNT_W'(1);
               state_n = MEASURE;
            end
         end
         MEASURE: begin
            if (!coin_db) begin
               state_n = CLASSIFY;
            end else begin
               len_n = len + CNT_W'(1);
               if (len == LEN_MAX - CNT_W'(1)) state_n = JAM;
            end
         end
         CLASSIFY: begin
            state_n = IDLE;
            if (valid && (!hm || ack)) begin
               hm_n = 1'b1;
               tm_n = is10;
            end else begin
               rej_n = 1'b1;
            end
         end
         JAM: begin
            if (!coin_db) begin
               rej_n   = 1'b1;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
      jam_n = (state_n == JAM);
   end

`ifdef MDC_COIN_COUNT_EN
   logic load_c;
   assign load_c = (state == CLASSIFY) && valid && (!hm || ack);

   // Audit counters saturate rather than wrap
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         coin_cnt5  <= '0;
         coin_cnt10 <= '0;
      end else if (load_c) begin
         if (is10) begin
            if (coin_cnt10 != 8'hFF) coin_cnt10 <= coin_cnt10 + 8'd1;
         end else begin
            if (coin_cnt5 != 8'hFF) coin_cnt5 <= coin_cnt5 + 8'd1;
         end
      end
   end
`else
   assign coin_cnt5  = '0;
   assign coin_cnt10 = '0;
`endif

endmodule
